// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: decodes MIPS ALU-class instructions from ID and queues them
// in a 2-entry skid buffer that issues to the EX stage ALU.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous flush, drops every held entry
//   in_valid/in_ready   decode-side handshake (in_ready registered)
//   opcode, funct, rs_data, rt_data, imm16, rt_addr, rd_addr   decode inputs
//   out_valid/out_ready issue-side handshake
//   alu_a, alu_b, alu_s, alu_cin                                ALU controls
//   is_slt, is_branch, branch_ne, wr_en, wr_addr                EX/WB qualifiers
//   illegal             sticky unsupported-instruction flag
module id_ex_alu_issue #(
    parameter bit LOGIC_IMM_SEXT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm16,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_s,
    output logic        alu_cin,
    output logic        is_slt,
    output logic        is_branch,
    output logic        branch_ne,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic        illegal
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned SW = 3;
    localparam int unsigned IW = 16;

    localparam logic [SW-1:0] ALU_XOR  = 3'b000;
    localparam logic [SW-1:0] ALU_ADD  = 3'b010;
    localparam logic [SW-1:0] ALU_SUB  = 3'b011;
    localparam logic [SW-1:0] ALU_OR   = 3'b100;
    localparam logic [SW-1:0] ALU_NOR  = 3'b101;
    localparam logic [SW-1:0] ALU_AND  = 3'b110;
    localparam logic [SW-1:0] ALU_ZERO = 3'b111;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [SW-1:0] s;
        logic          cin;
        logic          slt;
        logic          br;
        logic          bne;
        logic          wen;
        logic [RW-1:0] waddr;
    } issue_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    issue_t        r_main;
    issue_t        r_skid;
    issue_t        w_dec;
    logic          w_dec_illegal;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          r_illegal;
    logic          w_accept;
    logic          w_consume;
    logic          w_ld_main_dec;
    logic          w_ld_main_skid;
    logic          w_ld_skid;
    logic [DW-1:0] w_imm_sext;
    logic [DW-1:0] w_imm_zext;
    logic [DW-1:0] w_imm_logic;

    assign w_accept    = in_valid & r_in_ready;
    assign w_consume   = r_out_valid & out_ready;
    assign w_imm_sext  = {{(DW-IW){imm16[IW-1]}}, imm16};
    assign w_imm_zext  = {{(DW-IW){1'b0}}, imm16};
    assign w_imm_logic = LOGIC_IMM_SEXT ? w_imm_sext : w_imm_zext;

    // Instruction decode into the issue payload
    always_comb begin
        w_dec         = '0;
        w_dec.a       = rs_data;
        w_dec.b       = rt_data;
        w_dec.s       = ALU_ZERO;
        w_dec_illegal = 1'b0;
        unique case (opcode)
            6'b000000: begin
                w_dec.wen   = 1'b1;
                w_dec.waddr = rd_addr;
                unique case (funct)
                    6'b100000, 6'b100001: w_dec.s = ALU_ADD;
                    6'b100010, 6'b100011: begin
                        w_dec.s   = ALU_SUB;
                        w_dec.cin = 1'b1;
                    end
                    6'b100100: w_dec.s = ALU_AND;
                    6'b100101: w_dec.s = ALU_OR;
                    6'b100110: w_dec.s = ALU_XOR;
                    6'b100111: w_dec.s = ALU_NOR;
                    6'b101010: begin
                        w_dec.s   = ALU_SUB;
                        w_dec.cin = 1'b1;
                        w_dec.slt = 1'b1;
                    end
                    default: begin
                        w_dec.wen     = 1'b0;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
            6'b001000, 6'b001001, 6'b100011: begin
                w_dec.s     = ALU_ADD;
                w_dec.b     = w_imm_sext;
                w_dec.wen   = 1'b1;
                w_dec.waddr = rt_addr;
            end
            6'b001010: begin
                w_dec.s     = ALU_SUB;
                w_dec.cin   = 1'b1;
                w_dec.slt   = 1'b1;
                w_dec.b     = w_imm_sext;
                w_dec.wen   = 1'b1;
                w_dec.waddr = rt_addr;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                w_dec.s     = (opcode[1:0] == 2'b00) ? ALU_AND :
                              (opcode[1:0] == 2'b01) ? ALU_OR : ALU_XOR;
                w_dec.b     = w_imm_logic;
                w_dec.wen   = 1'b1;
                w_dec.waddr = rt_addr;
            end
            6'b101011: begin
                w_dec.s = ALU_ADD;
                w_dec.b = w_imm_sext;
            end
            6'b000100, 6'b000101: begin
                w_dec.s   = ALU_SUB;
                w_dec.cin = 1'b1;
                w_dec.br  = 1'b1;
                w_dec.bne = opcode[0];
            end
            6'b001111: begin
                w_dec.s     = ALU_OR;
                w_dec.a     = '0;
                w_dec.b     = {imm16, {(DW-IW){1'b0}}};
                w_dec.wen   = 1'b1;
                w_dec.waddr = rt_addr;
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    // Skid buffer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Skid buffer next-state and entry load controls
    always_comb begin
        w_next         = r_state;
        w_ld_main_dec  = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_next = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next        = ST_ONE;
                        w_ld_main_dec = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_ld_main_dec = 1'b1;
                    end else if (w_accept) begin
                        w_next    = ST_TWO;
                        w_ld_skid = 1'b1;
                    end else if (w_consume) begin
                        w_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a consume can happen
                    if (w_consume) begin
                        w_next         = ST_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    // Entry storage, handshake flags and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (w_ld_main_dec) begin
                r_main <= w_dec;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_dec;
            end
            r_out_valid <= (w_next != ST_EMPTY);
            r_in_ready  <= (w_next != ST_TWO);
            if (w_accept && !flush && w_dec_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign illegal   = r_illegal;
    assign alu_a     = r_main.a;
    assign alu_b     = r_main.b;
    assign alu_s     = r_main.s;
    assign alu_cin   = r_main.cin;
    assign is_slt    = r_main.slt;
    assign is_branch = r_main.br;
    assign branch_ne = r_main.bne;
    assign wr_en     = r_main.wen;
    assign wr_addr   = r_main.waddr;

endmodule
